mult_hilo_unit: RTL

MULT_HILO_UNIT -- requirements
Module: mult_hilo_unit

---
 rtl/mult_hilo_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/mult_hilo_unit.sv
// 32x32 multiplier with HI/LO result registers and mthi/mtlo writes.
// Define MULT_HILO_FWD_EN to accept a new START in WRITE (back-to-back issue).
module mult_hilo_unit #(
  parameter int LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [31:0] OP_A,
  input  logic [31:0] OP_B,
  input  logic        HI_WE,
  input  logic        LO_WE,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // state | meaning
  // IDLE  | accepting START and mthi/mtlo writes
  // CALC  | array product settling, counter running down to 0
  // WRITE | product just loaded into HI/LO, DONE high
  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        sgn_q;
  logic        accept;
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [63:0] prod_sel;

  // Both arrays see the held operands; extending to 64 bits keeps the
  // low 64 bits of each product exact for its interpretation.
  assign prod_u   = {32'd0, op_a_q} * {32'd0, op_b_q};
  assign prod_s   = $signed({{32{op_a_q[31]}}, op_a_q}) * $signed({{32{op_b_q[31]}}, op_b_q});
  assign prod_sel = sgn_q ? prod_s : prod_u;

`ifdef MULT_HILO_FWD_EN
  assign accept = START && ((state == IDLE) || (state == WRITE));
`else
  assign accept = START && (state == IDLE);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      op_a_q <= 32'd0;
      op_b_q <= 32'd0;
      sgn_q  <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      if (accept) begin
        op_a_q <= OP_A;
        op_b_q <= OP_B;
        sgn_q  <= SIGNED;
        cnt    <= CNT_LOAD;
      end
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (HI_WE) HI <= WDATA;
          if (LO_WE) LO <= WDATA;
          if (START) begin
            state <= CALC;
            BUSY  <= 1'b1;
          end
        end
        CALC: begin
          if (cnt == 4'd0) begin
            HI    <= prod_sel[63:32];
            LO    <= prod_sel[31:0];
            state <= WRITE;
            DONE  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WRITE: begin
          DONE <= 1'b0;
          if (accept) begin
            state <= CALC;
            BUSY  <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule
